// File: rtl/pll_cfg_sched_if.sv
// ---------------------------------------------------------------------------
// pll_cfg_sched_if
// Bundles the host request strobes, the CPU command/status PIOs and the
// per-PLL report flags of the PLL reconfiguration scheduler.
//   req/req_type : host -> scheduler, one-cycle job strobes and job types
//   cpu_cmd      : scheduler -> CPU, [0] start, [3:1] PLL index
//   cpu_type     : scheduler -> CPU, job type of the active job
//   cpu_stat     : CPU -> scheduler, [0] busy, [1] done, [2] error, [9:3] code
//   pll_busy/pll_done/pll_err/last_err/sched_busy : scheduler -> register file
// master: the side driving requests and CPU status; slave: the scheduler.
// ---------------------------------------------------------------------------
interface pll_cfg_sched_if #(
    parameter int N_PLL = 6
);
    logic [N_PLL-1:0]   req;
    logic [2*N_PLL-1:0] req_type;
    logic [3:0]         cpu_cmd;
    logic [1:0]         cpu_type;
    logic [9:0]         cpu_stat;
    logic [N_PLL-1:0]   pll_busy;
    logic [N_PLL-1:0]   pll_done;
    logic [N_PLL-1:0]   pll_err;
    logic [6:0]         last_err;
    logic               sched_busy;

    modport master (
        output req, req_type, cpu_stat,
        input  cpu_cmd, cpu_type, pll_busy, pll_done, pll_err, last_err, sched_busy
    );

    modport slave (
        input  req, req_type, cpu_stat,
        output cpu_cmd, cpu_type, pll_busy, pll_done, pll_err, last_err, sched_busy
    );
endinterface

// File: rtl/pll_cfg_sched.sv
// ---------------------------------------------------------------------------
// pll_cfg_sched
// Round-robin scheduler for PLL reconfiguration jobs executed by the soft CPU.
// Requests are captured into a pending vector, granted one at a time, handed
// to the CPU through the command PIO and tracked until the CPU reports done,
// error, or the timeout expires. Per-PLL sticky done/error flags are reported.
//   clk     : CPU system clock
//   reset_n : asynchronous active-low reset
//   bus     : pll_cfg_sched_if.slave (requests, CPU PIOs, report flags)
// ---------------------------------------------------------------------------
module pll_cfg_sched #(
    parameter int N_PLL       = 6,
    parameter int TIMEOUT_CYC = 10000000,
    parameter int TO_W        = 24
) (
    input  logic          clk,
    input  logic          reset_n,
    pll_cfg_sched_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t             state_r;
    logic [N_PLL-1:0]   pending_r;
    logic [2*N_PLL-1:0] type_r;
    logic [2:0]         rr_ptr_r;
    logic [2:0]         idx_r;
    logic [1:0]         jtype_r;
    logic [3:0]         cmd_r;
    logic [TO_W-1:0]    to_cnt_r;
    logic [9:0]         stat_r;
    logic [N_PLL-1:0]   pll_done_r;
    logic [N_PLL-1:0]   pll_err_r;
    logic [6:0]         last_err_r;

    logic [3:0]         pick_s;
    logic               stat_clear_s;
    logic               release_ok_s;
    logic               timeout_s;
    logic               outcome_done_s;
    logic               outcome_err_s;
    logic [6:0]         err_code_s;
    logic [N_PLL-1:0]   req_ok_s;
    logic [N_PLL-1:0]   req_bad_s;
    logic [N_PLL-1:0]   grant_clr_s;
    logic [N_PLL-1:0]   set_done_s;
    logic [N_PLL-1:0]   set_err_s;
    logic [N_PLL-1:0]   busy_s;

    // Round-robin search: first set bit of pend starting at ptr, wrapping.
    // Returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [N_PLL-1:0] pend,
                                           input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] c3;
        res = 4'b0000;
        // Walk downwards so the nearest candidate to ptr is written last.
        for (int k = N_PLL - 1; k >= 0; k--) begin
            c3 = 3'((int'(ptr) + k) % N_PLL);
            if (pend[c3]) begin
                res = {1'b1, c3};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Decode of grant choice, CPU status conditions, request classes and flag updates.
    always_comb begin
        pick_s         = rr_pick(pending_r, rr_ptr_r);
        stat_clear_s   = ~stat_r[1] & ~stat_r[2];
        release_ok_s   = (stat_r[2:0] == 3'b000);
        timeout_s      = (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));
        // Error beats done when both are reported together.
        outcome_err_s  = (state_r == WAIT) && (stat_r[2] || (!stat_r[1] && timeout_s));
        outcome_done_s = (state_r == WAIT) && stat_r[1] && !stat_r[2];
        err_code_s     = stat_r[2] ? stat_r[9:3] : 7'h7F;
        req_ok_s       = '0;
        req_bad_s      = '0;
        grant_clr_s    = '0;
        set_done_s     = '0;
        set_err_s      = '0;
        busy_s         = '0;
        for (int i = 0; i < N_PLL; i++) begin
            req_ok_s[i]    = bus.req[i] && (bus.req_type[2*i +: 2] != 2'b11);
            req_bad_s[i]   = bus.req[i] && (bus.req_type[2*i +: 2] == 2'b11);
            grant_clr_s[i] = (state_r == GRANT) && pick_s[3] && (pick_s[2:0] == 3'(i));
            set_done_s[i]  = outcome_done_s && (idx_r == 3'(i));
            set_err_s[i]   = outcome_err_s && (idx_r == 3'(i));
            busy_s[i]      = pending_r[i] ||
                             (((state_r == ISSUE) || (state_r == WAIT)) && (idx_r == 3'(i)));
        end
    end

    // Host-side state: pending vector, type store and sticky result flags.
    // A same-cycle request overrides grant clears and job outcomes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r  <= '0;
            type_r     <= '0;
            pll_done_r <= '0;
            pll_err_r  <= '0;
            last_err_r <= 7'h00;
        end else begin
            pending_r  <= (pending_r & ~grant_clr_s) | req_ok_s;
            for (int i = 0; i < N_PLL; i++) begin
                if (req_ok_s[i]) begin
                    type_r[2*i +: 2] <= bus.req_type[2*i +: 2];
                end else begin
                    type_r[2*i +: 2] <= type_r[2*i +: 2];
                end
            end
            pll_done_r <= (pll_done_r | set_done_s) & ~bus.req;
            pll_err_r  <= ((pll_err_r | set_err_s) & ~bus.req) | req_bad_s;
            if (|req_bad_s) begin
                last_err_r <= 7'h7E;
            end else if (outcome_err_s) begin
                last_err_r <= err_code_s;
            end else begin
                last_err_r <= last_err_r;
            end
        end
    end

    // Job FSM: grant, issue to the CPU, wait for an outcome, release the PIO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            rr_ptr_r <= 3'd0;
            idx_r    <= 3'd0;
            jtype_r  <= 2'b00;
            cmd_r    <= 4'b0000;
            to_cnt_r <= '0;
            stat_r   <= 10'd0;
        end else begin
            stat_r <= bus.cpu_stat;
            case (state_r)
                IDLE: begin
                    state_r <= (|pending_r) ? GRANT : IDLE;
                end
                GRANT: begin
                    if (pick_s[3]) begin
                        idx_r    <= pick_s[2:0];
                        jtype_r  <= type_r[{pick_s[2:0], 1'b0} +: 2];
                        rr_ptr_r <= (pick_s[2:0] == 3'(N_PLL - 1)) ? 3'd0 : pick_s[2:0] + 3'd1;
                        to_cnt_r <= '0;
                        // Raising start on the grant edge keeps request-to-start at 3 cycles.
                        if (stat_clear_s) begin
                            cmd_r   <= {pick_s[2:0], 1'b1};
                            state_r <= WAIT;
                        end else begin
                            cmd_r   <= {pick_s[2:0], 1'b0};
                            state_r <= ISSUE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (stat_clear_s) begin
                        cmd_r    <= {idx_r, 1'b1};
                        to_cnt_r <= '0;
                        state_r  <= WAIT;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                WAIT: begin
                    if (outcome_err_s || outcome_done_s) begin
                        cmd_r   <= 4'b0000;
                        jtype_r <= 2'b00;
                        state_r <= RELEASE;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                RELEASE: begin
                    state_r <= release_ok_s ? IDLE : RELEASE;
                end
                default: begin
                    cmd_r   <= 4'b0000;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_cmd    = cmd_r;
    assign bus.cpu_type   = jtype_r;
    assign bus.pll_busy   = busy_s;
    assign bus.pll_done   = pll_done_r;
    assign bus.pll_err    = pll_err_r;
    assign bus.last_err   = last_err_r;
    assign bus.sched_busy = (state_r != IDLE);

endmodule

// File: tb/tb_pll_cfg_sched.sv
module tb_pll_cfg_sched;
    localparam int N = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pll_cfg_sched_if #(.N_PLL(N)) bus ();

    pll_cfg_sched #(.N_PLL(N), .TIMEOUT_CYC(100), .TO_W(24)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct { int idx; logic [1:0] typ; } start_t;
    typedef struct { int idx; logic done; logic err; logic [6:0] code; } outc_t;

    start_t exp_start_q[$];
    outc_t  exp_out_q[$];
    int n_vec = 0;
    int n_err = 0;

    // CPU model controls: mode 0 = done, 1 = error, 2 = never answers
    int         cpu_mode = 0;
    int         cpu_lat  = 50;
    logic [6:0] cpu_code = 7'h00;
    int         cpu_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_job(input int idx, input logic [1:0] typ, input logic d,
                            input logic e, input logic [6:0] code, input bit with_out);
        start_t s;
        outc_t  o;
        s.idx = idx; s.typ = typ;
        exp_start_q.push_back(s);
        if (with_out) begin
            o.idx = idx; o.done = d; o.err = e; o.code = code;
            exp_out_q.push_back(o);
        end
    endtask

    task automatic drive(input logic [N-1:0] mask, input logic [2*N-1:0] types);
        @(negedge clk);
        bus.req = mask;
        bus.req_type = types;
        @(negedge clk);
        bus.req = '0;
        bus.req_type = '0;
    endtask

    task automatic wait_start(input int budget);
        int k;
        k = 0;
        while (!bus.cpu_cmd[0] && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!bus.cpu_cmd[0]) chk("wait_start_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((bus.sched_busy || (|bus.pll_busy)) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (bus.sched_busy || (|bus.pll_busy)) chk("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // CPU model: answers a raised start after cpu_lat cycles, clears once start drops.
    always @(negedge clk) begin
        if (!reset_n) begin
            bus.cpu_stat = 10'd0;
            cpu_cnt = 0;
        end else if (bus.cpu_cmd[0]) begin
            cpu_cnt++;
            if (cpu_mode == 2) bus.cpu_stat = 10'd0;
            else if (cpu_cnt >= cpu_lat)
                bus.cpu_stat = (cpu_mode == 0) ? {7'h00, 3'b011} : {cpu_code, 3'b101};
            else bus.cpu_stat = {7'h00, 3'b001};
        end else begin
            bus.cpu_stat = 10'd0;
            cpu_cnt = 0;
        end
    end

    // Monitor: checks each start against the expected grant and each end against the outcome.
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_start = 1'b0;
        end else begin
            if (bus.cpu_cmd[0] && !prev_start) begin
                if (exp_start_q.size() == 0) begin
                    chk("unexpected_start", {28'd0, bus.cpu_cmd}, 32'd0);
                end else begin
                    start_t s;
                    s = exp_start_q.pop_front();
                    chk("grant_idx_type", {27'd0, bus.cpu_cmd[3:1], bus.cpu_type},
                        {27'd0, 3'(s.idx), s.typ});
                end
            end
            if (!bus.cpu_cmd[0] && prev_start) begin
                if (exp_out_q.size() == 0) begin
                    chk("unexpected_end", 32'd1, 32'd0);
                end else begin
                    outc_t o;
                    o = exp_out_q.pop_front();
                    chk("job_outcome",
                        {23'd0, bus.pll_done[o.idx], bus.pll_err[o.idx],
                         (o.err ? bus.last_err : 7'h00)},
                        {23'd0, o.done, o.err, o.code});
                end
            end
            prev_start = bus.cpu_cmd[0];
        end
    end

    initial begin
        int cnt;
        bus.req = '0;
        bus.req_type = '0;
        bus.cpu_stat = 10'd0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {bus.cpu_cmd, bus.cpu_type, bus.pll_busy, bus.pll_done,
                              bus.pll_err, bus.last_err, bus.sched_busy}, 32'd0);
        reset_n = 1'b1;

        // 1: single job on PLL 2
        cpu_mode = 0; cpu_lat = 50;
        push_job(2, 2'b00, 1'b1, 1'b0, 7'h00, 1'b1);
        drive(6'b000100, 12'd0);
        repeat (2) @(negedge clk);
        chk("t1_cmd_latency", {28'd0, bus.cpu_cmd}, 32'h5);
        chk("t1_pll_busy", {26'd0, bus.pll_busy}, 32'h04);
        wait_idle(300);
        chk("t1_end_state", {bus.cpu_cmd, bus.pll_done, bus.sched_busy}, {4'b0000, 6'b000100, 1'b0});

        // 2: round robin
        do_reset();
        for (int i = 0; i < N; i++) push_job(i, 2'b00, 1'b1, 1'b0, 7'h00, 1'b1);
        drive(6'b111111, 12'd0);
        wait_idle(1000);
        push_job(0, 2'b00, 1'b1, 1'b0, 7'h00, 1'b1);
        push_job(5, 2'b00, 1'b1, 1'b0, 7'h00, 1'b1);
        drive(6'b100001, 12'd0);
        wait_idle(500);

        // 3: CPU error on PLL 4, then a new request clears the error
        cpu_mode = 1; cpu_lat = 10; cpu_code = 7'h15;
        push_job(4, 2'b00, 1'b0, 1'b1, 7'h15, 1'b1);
        drive(6'b010000, 12'd0);
        wait_idle(200);
        chk("t3_last_err", {25'd0, bus.last_err}, 32'h15);
        chk("t3_done_clear", {31'd0, bus.pll_done[4]}, 32'd0);
        cpu_mode = 0;
        push_job(4, 2'b01, 1'b1, 1'b0, 7'h00, 1'b1);
        drive(6'b010000, 12'b01 << 8);
        chk("t3_err_cleared", {31'd0, bus.pll_err[4]}, 32'd0);
        wait_idle(300);

        // 4: timeout with a silent CPU
        cpu_mode = 2;
        push_job(0, 2'b00, 1'b0, 1'b1, 7'h7F, 1'b1);
        drive(6'b000001, 12'd0);
        wait_start(20);
        cnt = 0;
        while (bus.cpu_cmd[0] && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        chk("t4_start_cycles", cnt, 32'd100);
        wait_idle(50);
        chk("t4_idle", {31'd0, bus.sched_busy}, 32'd0);

        // 5: merge before grant, then re-queue during WAIT
        cpu_mode = 0; cpu_lat = 30;
        push_job(1, 2'b01, 1'b1, 1'b0, 7'h00, 1'b1);
        push_job(1, 2'b00, 1'b1, 1'b0, 7'h00, 1'b1);
        @(negedge clk);
        bus.req = 6'b000010; bus.req_type = 12'b00 << 2;
        @(negedge clk);
        bus.req_type = 12'b01 << 2;
        @(negedge clk);
        bus.req = '0; bus.req_type = '0;
        wait_start(20);
        repeat (5) @(negedge clk);
        drive(6'b000010, 12'd0);
        wait_idle(500);

        // 6: reset in the middle of a job, then a reserved-type request
        cpu_mode = 2;
        push_job(0, 2'b10, 1'b0, 1'b0, 7'h00, 1'b0);
        drive(6'b000001, 12'b10);
        wait_start(20);
        repeat (5) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_async_reset", {bus.cpu_cmd, bus.cpu_type, bus.pll_busy, bus.pll_done,
                               bus.pll_err, bus.last_err, bus.sched_busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cpu_cmd[0] || bus.sched_busy) cnt++;
        end
        chk("t6_no_resume", cnt, 32'd0);
        drive(6'b001000, 12'b11 << 6);
        chk("t6_reserved_err", {19'd0, bus.pll_err, bus.last_err}, {19'd0, 6'b001000, 7'h7E});
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.cpu_cmd[0] || bus.sched_busy || (|bus.pll_busy)) cnt++;
        end
        chk("t6_reserved_no_job", cnt, 32'd0);

        chk("queues_drained", exp_start_q.size() + exp_out_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
